// File: rtl/memory_word_bank_pkg.sv
// Shared definitions for the byte-enabled word memory: lane width and FSM states.
package memory_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_word_bank_if.sv
// Request/response bus of memory_word_bank: valid/ready request in, fixed-latency response out.
// The response has no ready, so the consumer must take every rd_valid pulse.
interface memory_word_bank_if #(
  parameter int NUM_BYTES = 4,
  parameter int ADDR_W    = 10
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [NUM_BYTES-1:0]   byte_en;
  logic [ADDR_W-1:0]      addr;
  logic [8*NUM_BYTES-1:0] wr_data;
  logic                   rd_valid;
  logic [8*NUM_BYTES-1:0] rd_data;

  modport master (
    output req_valid, req_we, byte_en, addr, wr_data,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, byte_en, addr, wr_data,
    output req_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/mem_byte_col.sv
// One 8-bit lane of 2**ADDR_W entries; the read port is write-first and purely combinational.
// Registering of the read result is left to the instantiating level.
module mem_byte_col
  import memory_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  // A lane being written returns the new byte in the same cycle.
  assign rd_data = we ? wr_data : mem[addr];

endmodule

// File: rtl/memory_word_bank.sv
// Byte-enabled word memory with post-reset zero fill; response 1 cycle (OUT_REG=0) or 2 cycles
// (OUT_REG=1) after the accepting edge. Requests stall only during the fill; responses never stall.
module memory_word_bank
  import memory_pkg::*;
#(
  parameter int NUM_BYTES  = 4,
  parameter int ADDR_W     = 10,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  memory_word_bank_if.slave  bus
);

  localparam int                WORD_W    = BYTE_W * NUM_BYTES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam mem_state_e        RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  mem_state_e           state;
  logic [ADDR_W-1:0]    init_cnt;
  logic                 in_init;
  logic                 accept;
  logic [ADDR_W-1:0]    col_addr;
  logic [NUM_BYTES-1:0] col_we;
  logic [WORD_W-1:0]    col_wdat;
  logic [WORD_W-1:0]    col_rdat;

  logic                 acc_vld;
  logic [WORD_W-1:0]    acc_dat;
  logic                 src_vld;
  logic [WORD_W-1:0]    src_dat;
  logic                 rd_vld_q;
  logic [WORD_W-1:0]    rd_dat_q;

  assign in_init       = (state == ST_INIT);
  assign bus.req_ready = (state == ST_RUN);
  assign accept        = bus.req_valid && bus.req_ready;

  // The fill borrows the column port; requests cannot collide since req_ready is low.
  assign col_addr = in_init ? init_cnt : bus.addr;
  assign col_wdat = in_init ? '0 : bus.wr_data;
  assign col_we   = in_init ? '1 : ((accept && bus.req_we) ? bus.byte_en : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_STATE;
      init_cnt <= '0;
    end else if (in_init) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_ADDR) begin
        state <= ST_RUN;
      end
    end
  end

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_col
    mem_byte_col #(
      .ADDR_W (ADDR_W)
    ) u_col (
      .clk     (clk),
      .we      (col_we[k]),
      .addr    (col_addr),
      .wr_data (col_wdat[BYTE_W*k +: BYTE_W]),
      .rd_data (col_rdat[BYTE_W*k +: BYTE_W])
    );
  end

  // Capture the merged word at acceptance so a later write cannot alter an in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld <= 1'b0;
      acc_dat <= '0;
    end else begin
      acc_vld <= accept;
      if (accept) begin
        acc_dat <= col_rdat;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              mid_vld;
    logic [WORD_W-1:0] mid_dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mid_vld <= 1'b0;
        mid_dat <= '0;
      end else begin
        mid_vld <= acc_vld;
        if (acc_vld) begin
          mid_dat <= acc_dat;
        end
      end
    end

    assign src_vld = mid_vld;
    assign src_dat = mid_dat;
  end else begin : g_noreg
    assign src_vld = acc_vld;
    assign src_dat = acc_dat;
  end

  // rd_data holds the last response while rd_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= src_vld;
      if (src_vld) begin
        rd_dat_q <= src_dat;
      end
    end
  end

  assign bus.rd_valid = rd_vld_q;
  assign bus.rd_data  = rd_dat_q;

endmodule
